// File: rtl/float_to_int_seq.sv
// IEEE-754 single to signed OUT_W-bit integer converter: iterative SHIFT_STEP-bit aligner, valid/ready on both sides.
// Optional build macro FTOI_ROUND_NEAREST_EN selects round-to-nearest-even instead of truncation toward zero.
module float_to_int_seq #(
    parameter int OUT_W      = 32,
    parameter int SHIFT_STEP = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_float,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_int,
    output logic             out_ovf,
    output logic             out_nan,
    output logic             busy
);

    localparam int               MW      = (OUT_W > 24) ? OUT_W + 1 : 25;
    localparam logic [OUT_W-1:0] POS_MAX = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] NEG_MIN = {1'b1, {(OUT_W-1){1'b0}}};
    localparam logic signed [9:0] E_SAT  = 10'(OUT_W - 1);
    localparam logic [4:0]       STEP    = 5'(SHIFT_STEP);

    typedef enum logic [1:0] {IDLE, ALIGN, SIGN, HOLD} state_t;
    state_t state, state_n;

    logic             sign_r, sign_n;
    logic [MW-1:0]    mag, mag_n, mag_rnd;
    logic [4:0]       cnt, cnt_n;
    logic             left, left_n;
    logic [OUT_W-1:0] int_n;
    logic             ovf_n, nan_n;
`ifdef FTOI_ROUND_NEAREST_EN
    logic             guard, guard_n, sticky, sticky_n;
`endif

    logic [7:0]         exp_in;
    logic [22:0]        frac_in;
    logic [23:0]        mant_in;
    logic signed [9:0]  e_in;
    logic               accept;

    assign exp_in    = in_float[30:23];
    assign frac_in   = in_float[22:0];
    assign mant_in   = {exp_in != 8'd0, frac_in};
    assign e_in      = $signed({2'b00, exp_in}) - 10'sd127;
    assign in_ready  = (state == IDLE) && rst_n;
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == HOLD);
    assign busy      = (state != IDLE);

    always_comb begin
        state_n = state;
        sign_n  = sign_r;
        mag_n   = mag;
        cnt_n   = cnt;
        left_n  = left;
        int_n   = out_int;
        ovf_n   = out_ovf;
        nan_n   = out_nan;
        mag_rnd = mag;
`ifdef FTOI_ROUND_NEAREST_EN
        guard_n  = guard;
        sticky_n = sticky;
`endif
        case (state)
            IDLE: if (accept) begin
                sign_n = in_float[31];
                int_n  = '0;
                ovf_n  = 1'b0;
                nan_n  = 1'b0;
                mag_n  = '0;
                cnt_n  = '0;
                left_n = 1'b0;
`ifdef FTOI_ROUND_NEAREST_EN
                guard_n  = 1'b0;
                sticky_n = 1'b0;
`endif
                if (exp_in == 8'hFF && frac_in != '0) begin
                    nan_n   = 1'b1;
                    state_n = HOLD;
                end else if (e_in >= E_SAT) begin
                    // infinities land here too (e=128); only -2^(OUT_W-1) exactly is representable
                    if (in_float[31] && e_in == E_SAT && frac_in == '0) begin
                        int_n = NEG_MIN;
                    end else begin
                        int_n = in_float[31] ? NEG_MIN : POS_MAX;
                        ovf_n = 1'b1;
                    end
                    state_n = HOLD;
                end else if (e_in < 0) begin
`ifdef FTOI_ROUND_NEAREST_EN
                    guard_n  = &e_in;
                    sticky_n = (&e_in) ? (|frac_in) : (|mant_in);
`endif
                    state_n = SIGN;
                end else begin
                    mag_n   = MW'(mant_in);
                    left_n  = (e_in > 10'sd23);
                    cnt_n   = left_n ? 5'(e_in - 10'sd23) : 5'(10'sd23 - e_in);
                    state_n = (cnt_n == '0) ? SIGN : ALIGN;
                end
            end
            ALIGN: begin
                for (int unsigned i = 0; i < SHIFT_STEP; i++) begin
                    if (i < 32'(cnt)) begin
                        if (left) begin
                            mag_n = mag_n << 1;
                        end else begin
`ifdef FTOI_ROUND_NEAREST_EN
                            sticky_n = sticky_n | guard_n;
                            guard_n  = mag_n[0];
`endif
                            mag_n = mag_n >> 1;
                        end
                    end
                end
                cnt_n = (cnt > STEP) ? cnt - STEP : '0;
                if (cnt <= STEP) state_n = SIGN;
            end
            SIGN: begin
`ifdef FTOI_ROUND_NEAREST_EN
                if (guard && (sticky || mag[0])) mag_rnd = mag + MW'(1);
`endif
                if (mag_rnd > MW'(POS_MAX)) begin
                    int_n = sign_r ? NEG_MIN : POS_MAX;
                    ovf_n = 1'b1;
                end else begin
                    int_n = sign_r ? -mag_rnd[OUT_W-1:0] : mag_rnd[OUT_W-1:0];
                end
                state_n = HOLD;
            end
            HOLD: if (out_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sign_r  <= 1'b0;
            mag     <= '0;
            cnt     <= '0;
            left    <= 1'b0;
            out_int <= '0;
            out_ovf <= 1'b0;
            out_nan <= 1'b0;
`ifdef FTOI_ROUND_NEAREST_EN
            guard   <= 1'b0;
            sticky  <= 1'b0;
`endif
        end else begin
            sign_r  <= sign_n;
            mag     <= mag_n;
            cnt     <= cnt_n;
            left    <= left_n;
            out_int <= int_n;
            out_ovf <= ovf_n;
            out_nan <= nan_n;
`ifdef FTOI_ROUND_NEAREST_EN
            guard   <= guard_n;
            sticky  <= sticky_n;
`endif
        end
    end

endmodule
